// File: rtl/dmem_if.sv
// Data-memory controller bus bundle: two requester ports (CPU = 0, DMA = 1)
// plus the synchronous-write / asynchronous-read memory port.
//   slave  : seen by the controller (requests in, completions and memory strobes out)
//   master : seen by the requesters and the memory model
interface dmem_if;
  logic        req0, req1;
  logic        we0, we1;
  logic [1:0]  size0, size1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic        err0, err1;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wordIn;
  logic [31:0] mem_wordOut;

  modport slave (
    input  req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1,
    input  mem_wordOut,
    output ack0, ack1, rdata0, rdata1, err0, err1,
    output mem_write, mem_address, mem_wordIn
  );

  modport master (
    output req0, req1, we0, we1, size0, size1, addr0, addr1, wdata0, wdata1,
    output mem_wordOut,
    input  ack0, ack1, rdata0, rdata1, err0, err1,
    input  mem_write, mem_address, mem_wordIn
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Two-requester data-memory controller with round-robin arbitration,
// big-endian byte/half/word lanes and read-modify-write for sub-word stores.
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous active-high reset
//   bus (slave)  req/we/size/addr/wdata in, ack/err/rdata out per requester;
//                mem_write/mem_address/mem_wordIn out, mem_wordOut in
// rdata0/1 are combinational from mem_wordOut (the memory reads asynchronously
// and load data must appear in the same cycle as ack); all other outputs are flops.
module dmem_ctrl #(
  parameter int unsigned MEM_BYTES = 16384
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam logic [31:0] LAST_BYTE = 32'(MEM_BYTES - 1);
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, ERR = 2'd3} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic [31:0] mem_word_in_q, mem_word_in_d;

  logic        grant_c, bad_c, ack_c, err_c;
  logic        sel_we;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr, sel_wdata, rdata_c;

  // Pick the addressed byte/half (big endian) and zero-extend; words pass through.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0] size,
                                               input logic [1:0] off);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00: begin
        case (off)
          2'd0:    r = {24'd0, word[31:24]};
          2'd1:    r = {24'd0, word[23:16]};
          2'd2:    r = {24'd0, word[15:8]};
          default: r = {24'd0, word[7:0]};
        endcase
      end
      2'b01:   r = off[1] ? {16'd0, word[15:0]} : {16'd0, word[31:16]};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of word with the right-justified store data.
  function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                              input logic [31:0] data,
                                              input logic [1:0] size,
                                              input logic [1:0] off);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00: begin
        case (off)
          2'd0:    r[31:24] = data[7:0];
          2'd1:    r[23:16] = data[7:0];
          2'd2:    r[15:8]  = data[7:0];
          default: r[7:0]   = data[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) r[15:0] = data[15:0];
        else        r[31:16] = data[15:0];
      end
      default: r = data;
    endcase
    return r;
  endfunction

  // Round-robin choice and the selected requester's command.
  always_comb begin
    grant_c   = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
    sel_we    = grant_c ? bus.we1    : bus.we0;
    sel_size  = grant_c ? bus.size1  : bus.size0;
    sel_addr  = grant_c ? bus.addr1  : bus.addr0;
    sel_wdata = grant_c ? bus.wdata1 : bus.wdata0;
    case (sel_size)
      2'b00:   bad_c = sel_addr > LAST_BYTE;
      2'b01:   bad_c = sel_addr[0] || (sel_addr > LAST_BYTE);
      2'b10:   bad_c = (sel_addr[1:0] != 2'b00) || (sel_addr > LAST_WORD);
      default: bad_c = 1'b1;
    endcase
  end

  // Next state, latched command and registered outputs derived from the next state.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    gnt_d         = gnt_q;
    we_d          = we_q;
    size_d        = size_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    mem_word_in_d = 32'd0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          gnt_d        = grant_c;
          last_grant_d = grant_c;
          we_d         = sel_we;
          size_d       = sel_size;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          if (bad_c) begin
            state_d = ERR;
          end else if (sel_we && sel_size == 2'b10) begin
            state_d       = WR;
            mem_word_in_d = sel_wdata;
          end else begin
            // loads, and the read half of a sub-word read-modify-write
            state_d = RD;
          end
        end
      end
      RD: begin
        if (we_q) begin
          state_d       = WR;
          mem_word_in_d = lane_insert(bus.mem_wordOut, wdata_q, size_q, addr_q[1:0]);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    mem_write_d   = (state_d == WR);
    mem_address_d = (state_d == RD || state_d == WR) ? {addr_d[31:2], 2'b00} : 32'd0;
    ack_c         = (state_d == WR) || (state_d == ERR) || (state_d == RD && !we_d);
    err_c         = (state_d == ERR);
    ack0_d        = ack_c && !gnt_d;
    ack1_d        = ack_c && gnt_d;
    err0_d        = err_c && !gnt_d;
    err1_d        = err_c && gnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      gnt_q         <= 1'b0;
      we_q          <= 1'b0;
      size_q        <= 2'b00;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      err0_q        <= 1'b0;
      err1_q        <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= 32'd0;
      mem_word_in_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      gnt_q         <= gnt_d;
      we_q          <= we_d;
      size_q        <= size_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      err0_q        <= err0_d;
      err1_q        <= err1_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_word_in_q <= mem_word_in_d;
    end
  end

  // Load data exists only during the RD cycle of a load.
  assign rdata_c = (state_q == RD && !we_q) ?
                   lane_extract(bus.mem_wordOut, size_q, addr_q[1:0]) : 32'd0;

  assign bus.rdata0      = gnt_q ? 32'd0 : rdata_c;
  assign bus.rdata1      = gnt_q ? rdata_c : 32'd0;
  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.err0        = err0_q;
  assign bus.err1        = err1_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wordIn  = mem_word_in_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: word memory model on the memory port, byte-array reference
// model for expected results, directed scenarios followed by random accesses.
module tb_dmem_ctrl;

  localparam int unsigned MEM_BYTES = 16384;
  localparam int unsigned WORDS     = MEM_BYTES / 4;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  dmem_if bus ();

  dmem_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Memory: synchronous write, asynchronous read.
  logic [31:0] mem_w [WORDS];

  function automatic logic [31:0] init_word(input int i);
    if (i == 32'h40) return 32'h11223344;
    return (32'(i) * 32'h9E3779B1) ^ 32'hA5C30F1E;
  endfunction

  initial for (int i = 0; i < WORDS; i++) mem_w[i] = init_word(i);

  assign bus.mem_wordOut = mem_w[bus.mem_address[13:2]];
  always @(posedge clk) if (bus.mem_write) mem_w[bus.mem_address[13:2]] <= bus.mem_wordIn;

  // Reference model: flat byte array, big endian.
  logic [7:0] ref_b [MEM_BYTES];

  function automatic logic legal(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b0;
    if (sz == 2'b01 && a[0]) return 1'b0;
    if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b0;
    if (sz == 2'b10) return a <= 32'(MEM_BYTES - 4);
    return a < 32'(MEM_BYTES);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < (1 << sz); k++) v = (v << 8) | 32'(ref_b[a + 32'(k)]);
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n = 1 << sz;
    for (int k = 0; k < n; k++) ref_b[a + 32'(k)] = wd[8*(n-1-k) +: 8];
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int r, input logic rq, input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    if (r == 0) begin
      bus.req0 = rq; bus.we0 = w; bus.size0 = sz; bus.addr0 = a; bus.wdata0 = wd;
    end else begin
      bus.req1 = rq; bus.we1 = w; bus.size1 = sz; bus.addr1 = a; bus.wdata1 = wd;
    end
  endtask

  // One transaction from IDLE; called just after a falling edge.
  task automatic access(input string tag, input int r, input logic w, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    logic        ok, got, er;
    int          cyc, writes, other_bad, exp_lat;
    logic [31:0] wi, wa, exp_rd, exp_wi;
    ok = legal(sz, a);
    exp_rd  = (ok && !w) ? ref_load(sz, a) : 32'd0;
    exp_lat = (ok && w && sz != 2'b10) ? 2 : 1;
    got = 1'b0; er = 1'b0; rd = 32'd0; wi = 32'd0; wa = 32'd0;
    cyc = 0; writes = 0; other_bad = 0;
    drive(r, 1'b1, w, sz, a, wd);
    while (!got && cyc < 8) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (bus.mem_write) begin writes++; wi = bus.mem_wordIn; wa = bus.mem_address; end
      if (r == 0 && (bus.ack1 || bus.err1 || bus.rdata1 != 0)) other_bad++;
      if (r == 1 && (bus.ack0 || bus.err0 || bus.rdata0 != 0)) other_bad++;
      if ((r == 0) ? bus.ack0 : bus.ack1) begin
        got = 1'b1;
        er  = (r == 0) ? bus.err0 : bus.err1;
        rd  = (r == 0) ? bus.rdata0 : bus.rdata1;
      end
    end
    drive(r, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    check({tag, "_ack"}, 32'(got), 32'd1);
    check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_err"}, 32'(er), 32'(!ok));
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_writes"}, 32'(writes), 32'(ok && w));
    check({tag, "_other"}, 32'(other_bad), 32'd0);
    if (ok && w) begin
      ref_store(sz, a, wd);
      exp_wi = ref_load(2'b10, {a[31:2], 2'b00});
      check({tag, "_wordin"}, wi, exp_wi);
      check({tag, "_maddr"}, wa, {a[31:2], 2'b00});
    end
    @(posedge clk); @(negedge clk);
  endtask

  // Wait for whichever requester gets the next ack.
  task automatic wait_any(input string tag, output int who, output logic [31:0] rd);
    int cyc = 0;
    who = -1; rd = 32'd0;
    while (who < 0 && cyc < 8) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (bus.ack0) begin who = 0; rd = bus.rdata0; end
      else if (bus.ack1) begin who = 1; rd = bus.rdata1; end
    end
    check({tag, "_got"}, 32'(who >= 0), 32'd1);
    check({tag, "_single"}, 32'(bus.ack0 && bus.ack1), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, exp, a, wd;
    logic [1:0]  sz;
    logic        w;
    int          who, r, mism;

    for (int i = 0; i < WORDS; i++) begin
      exp = init_word(i);
      ref_b[4*i]   = exp[31:24];
      ref_b[4*i+1] = exp[23:16];
      ref_b[4*i+2] = exp[15:8];
      ref_b[4*i+3] = exp[7:0];
    end
    drive(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ack0", 32'(bus.ack0), 32'd0);
    check("rst_ack1", 32'(bus.ack1), 32'd0);
    check("rst_err", 32'({bus.err0, bus.err1}), 32'd0);
    check("rst_mem_write", 32'(bus.mem_write), 32'd0);
    check("rst_maddr", bus.mem_address, 32'd0);
    check("rst_wordin", bus.mem_wordIn, 32'd0);
    check("rst_rdata", bus.rdata0 | bus.rdata1, 32'd0);

    // Contest from reset with both requests held: CPU, DMA, CPU, DMA.
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 2'b10, 32'h100, 32'd0);
    drive(1, 1'b1, 1'b0, 2'b00, 32'h205, 32'd0);
    for (int i = 0; i < 4; i++) begin
      wait_any("arb", who, rd);
      check("arb_who", 32'(who), 32'(i % 2));
      exp = (who == 1) ? ref_load(2'b00, 32'h205) : ref_load(2'b10, 32'h100);
      check("arb_rdata", rd, exp);
    end
    drive(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    @(posedge clk); @(negedge clk);

    // CPU byte load, then a contest right after a CPU grant goes to DMA.
    access("ld_byte", 0, 1'b0, 2'b00, 32'h101, 32'd0, rd);
    check("ld_byte_const", rd, 32'h00000022);
    drive(0, 1'b1, 1'b0, 2'b00, 32'h103, 32'd0);
    drive(1, 1'b1, 1'b0, 2'b01, 32'h102, 32'd0);
    wait_any("arb2", who, rd);
    check("arb2_who", 32'(who), 32'd1);
    check("arb2_rdata", rd, 32'h00003344);
    drive(1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    wait_any("arb3", who, rd);
    check("arb3_who", 32'(who), 32'd0);
    check("arb3_rdata", rd, 32'h00000044);
    drive(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    @(posedge clk); @(negedge clk);

    // Byte read-modify-write and readback.
    access("st_byte", 0, 1'b1, 2'b00, 32'h102, 32'hFFFF_FFAB, rd);
    access("rb_word", 0, 1'b0, 2'b10, 32'h100, 32'd0, rd);
    check("rb_word_const", rd, 32'h1122AB44);

    // Rejected accesses.
    access("err_word_misal", 0, 1'b0, 2'b10, 32'h102, 32'd0, rd);
    access("err_oob_byte", 1, 1'b1, 2'b00, 32'h4000, 32'h55, rd);
    access("err_size3", 1, 1'b0, 2'b11, 32'h10, 32'd0, rd);
    access("err_half_odd", 0, 1'b1, 2'b01, 32'h201, 32'h1234, rd);

    // Reset in the RD cycle of a halfword store aborts it.
    drive(0, 1'b1, 1'b1, 2'b01, 32'h200, 32'h0000_5555);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_mw_now", 32'(bus.mem_write), 32'd0);
    @(posedge clk); #1;
    check("abort_mw_edge", 32'(bus.mem_write), 32'd0);
    check("abort_ack", 32'(bus.ack0), 32'd0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_mem", mem_w[32'h200 >> 2], ref_load(2'b10, 32'h200));
    access("after_abort", 0, 1'b0, 2'b01, 32'h200, 32'd0, rd);

    // Top-of-memory word store and half readback.
    access("st_top", 1, 1'b1, 2'b10, 32'h3FFC, 32'hDEADBEEF, rd);
    access("ld_top", 1, 1'b0, 2'b01, 32'h3FFE, 32'd0, rd);
    check("ld_top_const", rd, 32'h0000BEEF);
    access("err_word_top", 1, 1'b0, 2'b10, 32'h4000, 32'd0, rd);

    // Random traffic, biased toward the top boundary.
    for (int i = 0; i < 80; i++) begin
      r  = int'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0:       a = 32'h3FF0 + 32'($urandom_range(0, 23));
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, MEM_BYTES - 1));
      endcase
      if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      wd = $urandom;
      access("rnd", r, w, sz, a, wd, rd);
    end

    mism = 0;
    for (int i = 0; i < WORDS; i++)
      if (mem_w[i] !== ref_load(2'b10, 32'(4*i))) mism++;
    check("mem_sweep", 32'(mism), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
